calendar_date_counter: RTL and testbench

Parametrised day/month/year calendar counter for the clock/calendar datapath. It advances the date once per i_day_tick pulse, applies Gregorian leap-year rules and supports a validated synchronous date load. It emits registered month, year and wrap tick pulses for downstream display and alarm logic. At year end it either wraps to the epoch year or saturates, selected by parameter.

---
 rtl/calendar_pkg.sv | 35 +++
 rtl/calendar_date_validate.sv | 30 +++
 rtl/calendar_date_counter.sv | 140 ++++++++++++++
 tb/tb_calendar_date_counter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/calendar_pkg.sv
// rtl/calendar_pkg.sv - shared widths, month constants and calendar helper functions
package calendar_pkg;

    localparam int DAY_W   = 5;
    localparam int MONTH_W = 4;

    localparam logic [MONTH_W-1:0] JAN = 4'd1;
    localparam logic [MONTH_W-1:0] FEB = 4'd2;
    localparam logic [MONTH_W-1:0] MAR = 4'd3;
    localparam logic [MONTH_W-1:0] APR = 4'd4;
    localparam logic [MONTH_W-1:0] MAY = 4'd5;
    localparam logic [MONTH_W-1:0] JUN = 4'd6;
    localparam logic [MONTH_W-1:0] JUL = 4'd7;
    localparam logic [MONTH_W-1:0] AUG = 4'd8;
    localparam logic [MONTH_W-1:0] SEP = 4'd9;
    localparam logic [MONTH_W-1:0] OCT = 4'd10;
    localparam logic [MONTH_W-1:0] NOV = 4'd11;
    localparam logic [MONTH_W-1:0] DEC = 4'd12;

    // Gregorian rule; callers zero-extend their year field to 32 bits
    function automatic logic is_leap(input logic [31:0] year);
        return (year[1:0] == 2'b00) &&
               ((year % 32'd100 != 32'd0) || (year % 32'd400 == 32'd0));
    endfunction

    function automatic logic [DAY_W-1:0] days_in_month(input logic [MONTH_W-1:0] month,
                                                       input logic leap);
        case (month)
            FEB:               return leap ? 5'd29 : 5'd28;
            APR, JUN, SEP, NOV: return 5'd30;
            default:           return 5'd31;
        endcase
    endfunction

endpackage

// File: rtl/calendar_date_validate.sv
// rtl/calendar_date_validate.sv - combinational range check of a candidate day/month/year
module calendar_date_validate
    import calendar_pkg::*;
#(
    parameter int YEAR_WIDTH = 12,
    parameter int YEAR_MIN   = 1970,
    parameter int YEAR_MAX   = 4095
) (
    input  logic [DAY_W-1:0]      load_day,
    input  logic [MONTH_W-1:0]    load_month,
    input  logic [YEAR_WIDTH-1:0] load_year,
    output logic                  valid,
    output logic                  leap
);

    localparam logic [YEAR_WIDTH-1:0] Y_MIN = YEAR_WIDTH'(YEAR_MIN);
    localparam logic [YEAR_WIDTH-1:0] Y_MAX = YEAR_WIDTH'(YEAR_MAX);

    logic month_ok;
    logic day_ok;
    logic year_ok;

    assign leap     = is_leap(32'(load_year));
    assign month_ok = (load_month >= JAN) && (load_month <= DEC);
    // month_ok gates the result, so the 31-day default for bad months is harmless
    assign day_ok   = (load_day != '0) && (load_day <= days_in_month(load_month, leap));
    assign year_ok  = (load_year >= Y_MIN) && (load_year <= Y_MAX);
    assign valid    = month_ok && day_ok && year_ok;

endmodule

// File: rtl/calendar_date_counter.sv
// rtl/calendar_date_counter.sv - day/month/year counter with leap rules, load check and tick pulses
module calendar_date_counter
    import calendar_pkg::*;
#(
    parameter int YEAR_WIDTH = 12,
    parameter int YEAR_INIT  = 1970,
    parameter int YEAR_MAX   = 4095,
    parameter int WRAP_MODE  = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_srst,
    input  logic                  i_day_tick,
    input  logic                  i_load,
    input  logic [DAY_W-1:0]      i_load_day,
    input  logic [MONTH_W-1:0]    i_load_month,
    input  logic [YEAR_WIDTH-1:0] i_load_year,
    output logic [DAY_W-1:0]      o_day,
    output logic [MONTH_W-1:0]    o_month,
    output logic [YEAR_WIDTH-1:0] o_year,
    output logic                  o_leap,
    output logic                  o_month_tick,
    output logic                  o_year_tick,
    output logic                  o_wrap_tick,
    output logic                  o_load_err,
    output logic                  o_sat
);

    localparam logic [YEAR_WIDTH-1:0] Y_INIT = YEAR_WIDTH'(YEAR_INIT);
    localparam logic [YEAR_WIDTH-1:0] Y_MAX  = YEAR_WIDTH'(YEAR_MAX);

    logic [DAY_W-1:0]      day_q,   day_d;
    logic [MONTH_W-1:0]    month_q, month_d;
    logic [YEAR_WIDTH-1:0] year_q,  year_d;
    logic month_tick_q, month_tick_d;
    logic year_tick_q,  year_tick_d;
    logic wrap_tick_q,  wrap_tick_d;
    logic load_err_q,   load_err_d;
    logic sat_q,        sat_d;
    logic load_valid;
    logic unused_load_leap;
    logic [DAY_W-1:0] cur_days;

    calendar_date_validate #(
        .YEAR_WIDTH (YEAR_WIDTH),
        .YEAR_MIN   (YEAR_INIT),
        .YEAR_MAX   (YEAR_MAX)
    ) u_validate (
        .load_day   (i_load_day),
        .load_month (i_load_month),
        .load_year  (i_load_year),
        .valid      (load_valid),
        .leap       (unused_load_leap)
    );

    assign o_leap   = is_leap(32'(year_q));
    assign cur_days = days_in_month(month_q, o_leap);

    always_comb begin
        day_d        = day_q;
        month_d      = month_q;
        year_d       = year_q;
        sat_d        = sat_q;
        month_tick_d = 1'b0;
        year_tick_d  = 1'b0;
        wrap_tick_d  = 1'b0;
        load_err_d   = 1'b0;
        if (i_srst) begin
            day_d   = DAY_W'(1);
            month_d = JAN;
            year_d  = Y_INIT;
            sat_d   = 1'b0;
        end else if (i_load) begin
            if (load_valid) begin
                day_d   = i_load_day;
                month_d = i_load_month;
                year_d  = i_load_year;
                sat_d   = 1'b0;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (i_day_tick && !sat_q) begin
            if (day_q < cur_days) begin
                day_d = day_q + DAY_W'(1);
            end else if (month_q != DEC) begin
                day_d        = DAY_W'(1);
                month_d      = month_q + MONTH_W'(1);
                month_tick_d = 1'b1;
            end else if (year_q < Y_MAX) begin
                day_d        = DAY_W'(1);
                month_d      = JAN;
                year_d       = year_q + YEAR_WIDTH'(1);
                month_tick_d = 1'b1;
                year_tick_d  = 1'b1;
            end else if (WRAP_MODE != 0) begin
                day_d        = DAY_W'(1);
                month_d      = JAN;
                year_d       = Y_INIT;
                month_tick_d = 1'b1;
                year_tick_d  = 1'b1;
                wrap_tick_d  = 1'b1;
            end else begin
                // hold 31 Dec of the last year; further ticks are ignored until cleared
                sat_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            day_q        <= DAY_W'(1);
            month_q      <= JAN;
            year_q       <= Y_INIT;
            month_tick_q <= 1'b0;
            year_tick_q  <= 1'b0;
            wrap_tick_q  <= 1'b0;
            load_err_q   <= 1'b0;
            sat_q        <= 1'b0;
        end else begin
            day_q        <= day_d;
            month_q      <= month_d;
            year_q       <= year_d;
            month_tick_q <= month_tick_d;
            year_tick_q  <= year_tick_d;
            wrap_tick_q  <= wrap_tick_d;
            load_err_q   <= load_err_d;
            sat_q        <= sat_d;
        end
    end

    assign o_day        = day_q;
    assign o_month      = month_q;
    assign o_year       = year_q;
    assign o_month_tick = month_tick_q;
    assign o_year_tick  = year_tick_q;
    assign o_wrap_tick  = wrap_tick_q;
    assign o_load_err   = load_err_q;
    assign o_sat        = sat_q;

endmodule

// File: tb/tb_calendar_date_counter.sv
// tb/tb_calendar_date_counter.sv - bench for calendar_date_counter in wrap and saturate builds
module tb_calendar_date_counter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        srst = 1'b0;
    logic        day_tick = 1'b0;
    logic        load = 1'b0;
    logic [4:0]  load_day = '0;
    logic [3:0]  load_month = '0;
    logic [11:0] load_year = '0;

    logic [4:0]  w_day,   s_day;
    logic [3:0]  w_month, s_month;
    logic [11:0] w_year,  s_year;
    logic w_leap, w_mt, w_yt, w_wt, w_err, w_sat;
    logic s_leap, s_mt, s_yt, s_wt, s_err, s_sat;

    int n_checks = 0;
    int n_fail   = 0;

    // index 0: wrap build (YEAR_MAX 4095); index 1: saturate build (YEAR_MAX 2099)
    int ymax [2] = '{4095, 2099};
    int m_day [2], m_mon [2], m_yr [2];
    bit m_mt [2], m_yt [2], m_wt [2], m_err [2], m_sat [2];

    always #5 clk = ~clk;

    calendar_date_counter #(
        .YEAR_WIDTH (12), .YEAR_INIT (1970), .YEAR_MAX (4095), .WRAP_MODE (1)
    ) u_wrap (
        .i_clk (clk), .i_rst_n (rst_n), .i_srst (srst), .i_day_tick (day_tick),
        .i_load (load), .i_load_day (load_day), .i_load_month (load_month),
        .i_load_year (load_year), .o_day (w_day), .o_month (w_month), .o_year (w_year),
        .o_leap (w_leap), .o_month_tick (w_mt), .o_year_tick (w_yt), .o_wrap_tick (w_wt),
        .o_load_err (w_err), .o_sat (w_sat)
    );

    calendar_date_counter #(
        .YEAR_WIDTH (12), .YEAR_INIT (1970), .YEAR_MAX (2099), .WRAP_MODE (0)
    ) u_sat (
        .i_clk (clk), .i_rst_n (rst_n), .i_srst (srst), .i_day_tick (day_tick),
        .i_load (load), .i_load_day (load_day), .i_load_month (load_month),
        .i_load_year (load_year), .o_day (s_day), .o_month (s_month), .o_year (s_year),
        .o_leap (s_leap), .o_month_tick (s_mt), .o_year_tick (s_yt), .o_wrap_tick (s_wt),
        .o_load_err (s_err), .o_sat (s_sat)
    );

    function automatic bit ref_leap(int y);
        return (y % 4 == 0) && ((y % 100 != 0) || (y % 400 == 0));
    endfunction

    function automatic int ref_dim(int m, int y);
        int t [12];
        t = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
        return t[m-1] + ((m == 2 && ref_leap(y)) ? 1 : 0);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_day[k] = 1; m_mon[k] = 1; m_yr[k] = 1970;
            m_mt[k] = 0; m_yt[k] = 0; m_wt[k] = 0; m_err[k] = 0; m_sat[k] = 0;
        end
    endtask

    task automatic model_step(input bit s, input bit l, input int ld, input int lm,
                              input int ly, input bit t);
        for (int k = 0; k < 2; k++) begin
            m_mt[k] = 0; m_yt[k] = 0; m_wt[k] = 0; m_err[k] = 0;
            if (s) begin
                m_day[k] = 1; m_mon[k] = 1; m_yr[k] = 1970; m_sat[k] = 0;
            end else if (l) begin
                if (lm >= 1 && lm <= 12 && ly >= 1970 && ly <= ymax[k] &&
                    ld >= 1 && ld <= ref_dim(lm, ly)) begin
                    m_day[k] = ld; m_mon[k] = lm; m_yr[k] = ly; m_sat[k] = 0;
                end else begin
                    m_err[k] = 1;
                end
            end else if (t && !m_sat[k]) begin
                if (m_day[k] < ref_dim(m_mon[k], m_yr[k])) begin
                    m_day[k]++;
                end else if (m_mon[k] < 12) begin
                    m_day[k] = 1; m_mon[k]++; m_mt[k] = 1;
                end else if (m_yr[k] < ymax[k]) begin
                    m_day[k] = 1; m_mon[k] = 1; m_yr[k]++; m_mt[k] = 1; m_yt[k] = 1;
                end else if (k == 0) begin
                    m_day[k] = 1; m_mon[k] = 1; m_yr[k] = 1970;
                    m_mt[k] = 1; m_yt[k] = 1; m_wt[k] = 1;
                end else begin
                    m_sat[k] = 1;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("wrap day",   32'(w_day),   m_day[0]);
        chk("wrap month", 32'(w_month), m_mon[0]);
        chk("wrap year",  32'(w_year),  m_yr[0]);
        chk("wrap leap",  32'(w_leap),  32'(ref_leap(m_yr[0])));
        chk("wrap mtick", 32'(w_mt),    32'(m_mt[0]));
        chk("wrap ytick", 32'(w_yt),    32'(m_yt[0]));
        chk("wrap wtick", 32'(w_wt),    32'(m_wt[0]));
        chk("wrap lderr", 32'(w_err),   32'(m_err[0]));
        chk("wrap sat",   32'(w_sat),   32'(m_sat[0]));
        chk("sat day",    32'(s_day),   m_day[1]);
        chk("sat month",  32'(s_month), m_mon[1]);
        chk("sat year",   32'(s_year),  m_yr[1]);
        chk("sat leap",   32'(s_leap),  32'(ref_leap(m_yr[1])));
        chk("sat mtick",  32'(s_mt),    32'(m_mt[1]));
        chk("sat ytick",  32'(s_yt),    32'(m_yt[1]));
        chk("sat wtick",  32'(s_wt),    32'(m_wt[1]));
        chk("sat lderr",  32'(s_err),   32'(m_err[1]));
        chk("sat sat",    32'(s_sat),   32'(m_sat[1]));
    endtask

    task automatic cyc(input bit s, input bit l, input int ld, input int lm,
                       input int ly, input bit t);
        @(negedge clk);
        srst = s; load = l; day_tick = t;
        load_day = 5'(ld); load_month = 4'(lm); load_year = 12'(ly);
        @(posedge clk);
        #1;
        model_step(s, l, ld, lm, ly, t);
        check_all();
        srst = 0; load = 0; day_tick = 0;
    endtask

    initial begin
        int r, ld, lm, ly;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_all();
        repeat (10) cyc(0, 0, 0, 0, 0, 0);

        cyc(0, 1, 28, 2, 2024, 0);
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);
        chk("leap rollover to 1 Mar", 32'(w_day), 1);
        cyc(0, 0, 0, 0, 0, 0);

        cyc(0, 1, 28, 2, 1900, 0);
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 1, 29, 2, 2023, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 1, 5, 13, 2000, 0);
        cyc(0, 1, 0, 5, 2000, 0);
        cyc(0, 1, 1, 1, 1969, 0);

        cyc(0, 1, 31, 12, 1999, 0);
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0);

        cyc(0, 1, 31, 12, 4095, 0);
        cyc(0, 0, 0, 0, 0, 1);
        chk("wrap to epoch year", 32'(w_year), 1970);
        cyc(0, 1, 31, 12, 2099, 0);
        cyc(0, 0, 0, 0, 0, 1);
        chk("saturate flag", 32'(s_sat), 1);
        repeat (5) cyc(0, 0, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 1, 31, 12, 2099, 0);
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 1, 15, 7, 2050, 0);

        cyc(1, 1, 10, 6, 2010, 1);
        cyc(0, 1, 10, 6, 2010, 1);
        cyc(0, 0, 0, 0, 0, 1);

        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        cyc(0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 2) begin
                cyc(1, $urandom_range(0, 1), 1, 1, 2000, $urandom_range(0, 1));
            end else if (r < 14) begin
                case ($urandom_range(0, 3))
                    0: begin ld = 31; lm = 12; end
                    1: begin ld = $urandom_range(27, 29); lm = 2; end
                    default: begin ld = $urandom_range(0, 31); lm = $urandom_range(0, 15); end
                endcase
                case ($urandom_range(0, 3))
                    0: ly = $urandom_range(4090, 4095);
                    1: ly = $urandom_range(2095, 2101);
                    2: ly = 4 * $urandom_range(490, 520);
                    default: ly = $urandom_range(1960, 2110);
                endcase
                cyc(0, 1, ld, lm, ly, $urandom_range(0, 1));
            end else begin
                cyc(0, 0, 0, 0, 0, r < 85);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
